// File: rtl/nnet_argmax_stage.sv
// nnet_argmax_stage
//
// Reduces each result vector from the neural-net score stream to a single word that holds the
// index and value of the largest signed score. Vector length comes from vec_len, which is
// sampled when the first score of each vector is accepted. s_axis_data_tlast is not used.
// Ties keep the lowest index. One result word is emitted per vector as a one-word packet.
//
// Parameters
//   DATA_W  width of one signed score, taken from s_axis_data_tdata[DATA_W-1:0]
//   CNT_W   width of vec_len and of the class-index counter
//
// Ports
//   ap_clk              clock, rising edge
//   ap_rst_n            asynchronous active-low reset
//   vec_len             scores per vector (0 is treated as 1)
//   s_axis_data_*       score stream in (tdata, tvalid, tready, tlast)
//   m_axis_data_*       result stream out: tdata = {index[15:0], max score sign-extended to 16}
//   vec_count           result words delivered since reset, wraps modulo 2^32

module nnet_argmax_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic [CNT_W-1:0] vec_len,
   input  logic [31:0]      s_axis_data_tdata,
   input  logic             s_axis_data_tvalid,
   output logic             s_axis_data_tready,
   input  logic             s_axis_data_tlast,
   output logic [31:0]      m_axis_data_tdata,
   output logic             m_axis_data_tvalid,
   input  logic             m_axis_data_tready,
   output logic             m_axis_data_tlast,
   output logic [31:0]      vec_count
);

   typedef enum logic [0:0] {
      StAccum,
      StEmit
   } state_e;

   state_e                    state_q, state_d;
   // Holds tready low through reset and releases it on the first edge afterwards.
   logic                      alive_q;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]          len_q, len_d;
   logic signed [DATA_W-1:0]  max_q, max_d;
   logic [CNT_W-1:0]          idx_q, idx_d;
   logic [31:0]               res_q, res_d;
   logic [31:0]               count_q, count_d;

   logic signed [DATA_W-1:0]  score;
   logic                      s_rdy;
   logic                      s_acc;
   logic                      first;
   logic [CNT_W-1:0]          len_in;
   logic [CNT_W-1:0]          len_cur;
   logic                      is_last;
   logic                      take;
   logic signed [DATA_W-1:0]  new_max;
   logic [CNT_W-1:0]          new_idx;
   logic [15:0]               idx16;
   logic [15:0]               max16;

   // ------------------------------------------------------------------------------------------
   // Score datapath
   // ------------------------------------------------------------------------------------------
   assign score = signed'(s_axis_data_tdata[DATA_W-1:0]);

   assign s_rdy = alive_q && (state_q == StAccum);
   assign s_acc = s_axis_data_tvalid && s_rdy;

   // The sample counter is zero exactly when the next accepted score starts a new vector.
   assign first   = (cnt_q == '0);
   assign len_in  = (vec_len == '0) ? CNT_W'(1) : vec_len;
   // The first score must be judged against the live vec_len since len_q is not loaded yet.
   assign len_cur = first ? len_in : len_q;
   assign is_last = (cnt_q == (len_cur - CNT_W'(1)));

   // Strictly-greater replace so equal scores keep the earlier (lower) index.
   assign take    = first || (score > max_q);
   assign new_max = take ? score : max_q;
   assign new_idx = first ? '0 : (take ? cnt_q : idx_q);

   // Result word formatting: index zero-extended or truncated, score sign-extended or truncated.
   generate
      if (CNT_W >= 16) begin : g_idx_trunc
         assign idx16 = new_idx[15:0];
      end else begin : g_idx_ext
         assign idx16 = {{(16 - CNT_W){1'b0}}, new_idx};
      end

      if (DATA_W >= 16) begin : g_max_trunc
         assign max16 = new_max[15:0];
      end else begin : g_max_ext
         assign max16 = {{(16 - DATA_W){new_max[DATA_W-1]}}, new_max};
      end

      if (DATA_W < 32) begin : g_unused_hi
         logic unused_in;
         assign unused_in = ^{s_axis_data_tdata[31:DATA_W], s_axis_data_tlast};
      end else begin : g_unused_last
         logic unused_in;
         assign unused_in = s_axis_data_tlast;
      end
   endgenerate

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      max_d   = max_q;
      idx_d   = idx_q;
      res_d   = res_q;
      count_d = count_q;

      unique case (state_q)
         StAccum: begin
            if (s_acc) begin
               max_d = new_max;
               idx_d = new_idx;
               cnt_d = cnt_q + CNT_W'(1);
               if (first) begin
                  len_d = len_in;
               end
               if (is_last) begin
                  // Result is frozen here so tdata stays stable for the whole EMIT period.
                  res_d   = {idx16, max16};
                  state_d = StEmit;
               end
            end
         end

         StEmit: begin
            if (m_axis_data_tready) begin
               state_d = StAccum;
               cnt_d   = '0;
               count_d = count_q + 32'd1;
            end
         end

         default: begin
            state_d = StAccum;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= StAccum;
         alive_q <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
         max_q   <= '0;
         idx_q   <= '0;
         res_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         count_q <= count_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign s_axis_data_tready = s_rdy;
   assign m_axis_data_tvalid = (state_q == StEmit);
   assign m_axis_data_tlast  = (state_q == StEmit);
   assign m_axis_data_tdata  = res_q;
   assign vec_count          = count_q;

endmodule

// File: tb/tb_nnet_argmax_stage.sv
// Directed bench for nnet_argmax_stage: a table of single vectors with hand-computed result
// words, then hand-written sequences for back-pressure, mid-vector vec_len change and
// mid-vector reset.

module tb_nnet_argmax_stage;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic [15:0] vec_len;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [31:0] vec_count;

   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] exp_count;

   typedef struct {
      logic [15:0]        len;
      logic [0:3][31:0]   s;
      logic [31:0]        exp;
   } vec_t;

   vec_t tab[9];

   nnet_argmax_stage #(
      .DATA_W (16),
      .CNT_W  (16)
   ) dut (
      .ap_clk             (ap_clk),
      .ap_rst_n           (ap_rst_n),
      .vec_len            (vec_len),
      .s_axis_data_tdata  (s_tdata),
      .s_axis_data_tvalid (s_tvalid),
      .s_axis_data_tready (s_tready),
      .s_axis_data_tlast  (s_tlast),
      .m_axis_data_tdata  (m_tdata),
      .m_axis_data_tvalid (m_tvalid),
      .m_axis_data_tready (m_tready),
      .m_axis_data_tlast  (m_tlast),
      .vec_count          (vec_count)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, nvec=%0d", nvec);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Present one score and hold it until accepted (bounded wait).
   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      s_tdata  = w;
      s_tvalid = 1'b1;
      while (!s_tready && n < 50) begin
         tick();
         n++;
      end
      if (!s_tready) check("send_timeout_tready", {31'b0, s_tready}, 32'd1);
      tick();
      s_tvalid = 1'b0;
   endtask

   // One full vector with m_tready held high; checks the 1-cycle result latency and handshake.
   task automatic run_vec(input vec_t v, input string name);
      int n;
      n = (v.len == 16'd0) ? 1 : int'(v.len);
      vec_len  = v.len;
      m_tready = 1'b1;
      for (int i = 0; i < n; i++) begin
         send(v.s[i]);
         if (i < n - 1) check({name, "_tvalid_early"}, {31'b0, m_tvalid}, 32'd0);
      end
      check({name, "_tvalid"}, {31'b0, m_tvalid}, 32'd1);
      check({name, "_tdata"}, m_tdata, v.exp);
      check({name, "_tlast"}, {31'b0, m_tlast}, 32'd1);
      check({name, "_stready_emit"}, {31'b0, s_tready}, 32'd0);
      tick();
      exp_count = exp_count + 32'd1;
      check({name, "_tvalid_after"}, {31'b0, m_tvalid}, 32'd0);
      check({name, "_stready_after"}, {31'b0, s_tready}, 32'd1);
      check({name, "_vec_count"}, vec_count, exp_count);
   endtask

   initial begin
      tab[0] = '{16'd4, {32'd3, 32'hFFFF_FFFE, 32'd9, 32'd1}, 32'h0002_0009};
      tab[1] = '{16'd3, {32'd5, 32'd5, 32'd5, 32'd0}, 32'h0000_0005};
      tab[2] = '{16'd3, {32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0}, 32'h0001_FFFD};
      tab[3] = '{16'd0, {32'h0000_1234, 32'd0, 32'd0, 32'd0}, 32'h0000_1234};
      tab[4] = '{16'd1, {32'h0000_8000, 32'd0, 32'd0, 32'd0}, 32'h0000_8000};
      tab[5] = '{16'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0}, 32'h0003_0000};
      tab[6] = '{16'd2, {32'h0000_7FFF, 32'h0000_8000, 32'd0, 32'd0}, 32'h0000_7FFF};
      tab[7] = '{16'd2, {32'hABCD_0001, 32'h0000_0002, 32'd0, 32'd0}, 32'h0001_0002};
      tab[8] = '{16'd3, {32'h0000_8000, 32'h0000_8001, 32'h0000_8000, 32'd0}, 32'h0001_8001};

      ap_rst_n  = 1'b0;
      vec_len   = 16'd4;
      s_tdata   = 32'd0;
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      m_tready  = 1'b1;
      exp_count = 32'd0;

      // Reset values.
      #2;
      check("rst_stready", {31'b0, s_tready}, 32'd0);
      check("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
      check("rst_tlast", {31'b0, m_tlast}, 32'd0);
      check("rst_tdata", m_tdata, 32'd0);
      check("rst_vec_count", vec_count, 32'd0);
      tick();
      tick();
      ap_rst_n = 1'b1;
      check("rst_rel_stready_low", {31'b0, s_tready}, 32'd0);
      tick();
      check("rst_rel_stready_high", {31'b0, s_tready}, 32'd1);

      // Table-driven single vectors.
      for (int i = 0; i < 9; i++) begin
         run_vec(tab[i], $sformatf("vec%0d", i));
      end

      // Back-pressure: result held, third score held upstream, then index 0 of the next vector.
      vec_len  = 16'd2;
      m_tready = 1'b0;
      send(32'd4);
      send(32'd7);
      s_tdata  = 32'd10;
      s_tvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_tvalid", {31'b0, m_tvalid}, 32'd1);
         check("bp_tdata", m_tdata, 32'h0001_0007);
         check("bp_stready", {31'b0, s_tready}, 32'd0);
         tick();
      end
      m_tready = 1'b1;
      tick();
      exp_count = exp_count + 32'd1;
      check("bp_tvalid_after", {31'b0, m_tvalid}, 32'd0);
      check("bp_stready_after", {31'b0, s_tready}, 32'd1);
      check("bp_vec_count", vec_count, exp_count);
      send(32'd10);
      check("bp_held_tvalid", {31'b0, m_tvalid}, 32'd0);
      send(32'hFFFF_FFFB);
      check("bp_next_tvalid", {31'b0, m_tvalid}, 32'd1);
      check("bp_next_tdata", m_tdata, 32'h0000_000A);
      tick();
      exp_count = exp_count + 32'd1;
      check("bp_next_vec_count", vec_count, exp_count);

      // vec_len change mid-vector takes effect only on the next vector.
      vec_len = 16'd4;
      send(32'd1);
      vec_len = 16'd2;
      send(32'd2);
      check("len_chg_tvalid2", {31'b0, m_tvalid}, 32'd0);
      send(32'd3);
      check("len_chg_tvalid3", {31'b0, m_tvalid}, 32'd0);
      send(32'd8);
      check("len_chg_tvalid4", {31'b0, m_tvalid}, 32'd1);
      check("len_chg_tdata", m_tdata, 32'h0003_0008);
      tick();
      exp_count = exp_count + 32'd1;
      send(32'd6);
      check("len_chg_next_tvalid1", {31'b0, m_tvalid}, 32'd0);
      send(32'd5);
      check("len_chg_next_tvalid2", {31'b0, m_tvalid}, 32'd1);
      check("len_chg_next_tdata", m_tdata, 32'h0000_0006);
      tick();
      exp_count = exp_count + 32'd1;
      check("len_chg_vec_count", vec_count, exp_count);

      // Reset in the middle of a vector discards it and restarts vec_count.
      vec_len = 16'd4;
      send(32'd100);
      send(32'd200);
      ap_rst_n = 1'b0;
      #1;
      exp_count = 32'd0;
      check("mid_rst_stready", {31'b0, s_tready}, 32'd0);
      check("mid_rst_tvalid", {31'b0, m_tvalid}, 32'd0);
      check("mid_rst_tlast", {31'b0, m_tlast}, 32'd0);
      check("mid_rst_tdata", m_tdata, 32'd0);
      check("mid_rst_vec_count", vec_count, 32'd0);
      tick();
      tick();
      ap_rst_n = 1'b1;
      check("mid_rst_rel_low", {31'b0, s_tready}, 32'd0);
      tick();
      check("mid_rst_rel_high", {31'b0, s_tready}, 32'd1);
      run_vec('{16'd4, {32'd1, 32'd2, 32'd3, 32'd0}, 32'h0002_0003}, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/nnet_argmax_stage.md
NNET_ARGMAX_STAGE -- requirements
Module: nnet_argmax_stage

Interface
REQ-001 Parameter DATA_W, default 16: width of one signed score taken from s_axis_data_tdata[DATA_W-1:0].
REQ-002 Parameter CNT_W, default 16: width of the vector-length input and the class-index counter.
REQ-003 ap_clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 ap_rst_n  input  1  reset, asynchronous assert, active-low; no other clock or reset exists.
REQ-005 vec_len  input  CNT_W  scores per result vector; same value the neural-net block drives on const_size_out.
REQ-006 s_axis_data_tdata  input  32  score word from the neural-net res_V_V stream; bits [31:DATA_W] ignored.
REQ-007 s_axis_data_tvalid  input  1  score valid.
REQ-008 s_axis_data_tready  output  1  stage accepts a score.
REQ-009 s_axis_data_tlast  input  1  ignored; vector boundaries come from vec_len only.
REQ-010 m_axis_data_tdata  output  32  result word {class index [31:16], max score sign-extended to 16 bits [15:0]}.
REQ-011 m_axis_data_tvalid  output  1  result valid.
REQ-012 m_axis_data_tready  input  1  downstream (nnet_vector_wrapper output side) accepts result.
REQ-013 m_axis_data_tlast  output  1  asserted with every result word; one-word packets.
REQ-014 vec_count  output  32  number of result words delivered since reset; wraps modulo 2^32.

Function
REQ-015 Two states: ACCUM (collecting scores) and EMIT (holding result); reset state is ACCUM.
REQ-016 In ACCUM, s_axis_data_tready SHALL be 1; in EMIT it SHALL be 0.
REQ-017 A score is accepted on a cycle with s_axis_data_tvalid and s_axis_data_tready both 1.
REQ-018 The effective length L SHALL be latched from vec_len on acceptance of the first score of a vector; vec_len changes mid-vector have no effect until the next vector.
REQ-019 vec_len = 0 SHALL be treated as L = 1.
REQ-020 First score of a vector unconditionally loads max score and index 0; each later score i replaces them only if strictly greater (signed compare), so ties keep the lowest index.
REQ-021 On acceptance of score L-1, state SHALL go to EMIT on the next edge with m_axis_data_tvalid = 1 and the final {index, max}; latency from last accepted score to tvalid is exactly 1 cycle.
REQ-022 In EMIT, m_axis_data_tdata and m_axis_data_tlast SHALL hold stable until m_axis_data_tvalid and m_axis_data_tready are both 1.
REQ-023 On the output handshake cycle: next edge returns to ACCUM, deasserts m_axis_data_tvalid, increments vec_count, clears the sample counter.
REQ-024 Score index counter is CNT_W bits; index reported is 0..L-1; counter resets to 0 at each vector start.
REQ-025 No score is dropped or duplicated: a score presented while in EMIT is held upstream by tready = 0 and accepted in ACCUM.
REQ-026 m_axis_data_tdata[31:16] = index zero-extended to 16 bits when CNT_W < 16, truncated to 16 bits when CNT_W > 16.

Reset
REQ-027 While ap_rst_n = 0: state ACCUM, s_axis_data_tready = 0, m_axis_data_tvalid = 0, m_axis_data_tlast = 0, m_axis_data_tdata = 0, vec_count = 0, counters and max register cleared.
REQ-028 s_axis_data_tready SHALL rise on the first edge after ap_rst_n deasserts.
REQ-029 Reset asserted mid-vector or during EMIT SHALL discard the partial vector or pending result; the first vector after reset starts at index 0.

Verification
REQ-030 vec_len=4, scores 3,-2,9,1, m_tready=1 -> one word 0x00020009, tlast=1, tvalid 1 cycle after 4th accept, vec_count=1.
REQ-031 vec_len=3, scores 5,5,5 -> 0x00000005 (tie keeps index 0); scores -7,-3,-3 -> 0x0001FFFD.
REQ-032 vec_len=2, m_tready=0 for 10 cycles after result -> tdata stable, s_tready=0 throughout, third score held; after handshake s_tready=1 next cycle and the held score is index 0 of the next vector.
REQ-033 vec_len changed 4->2 after first score of a vector -> that vector still consumes 4 scores; next vector consumes 2.
REQ-034 vec_len=0, single score 0x1234 -> result 0x00001234 after one score.
REQ-035 ap_rst_n pulsed low after 2 of 4 scores -> all outputs at reset values; next 4 scores produce a correct independent result; vec_count restarts at 0.
